// File: rtl/rxc_pkg.sv
// Shared constants and state encoding for the alink receive controller.
package rxc_pkg;

   localparam int PHY_NUM_DEF = 16;
   localparam int RR_W_DEF    = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_RECV = 2'b10
   } rxc_state_e;

endpackage

// File: rtl/rxc_if.sv
// PHY-side handshake bundle: master = receive controller, slave = PHY/FIFO side.
interface rxc_if
   import rxc_pkg::*;
#(
   parameter int PHY_NUM = PHY_NUM_DEF
);

   logic [PHY_NUM-1:0] rx_phy_req;
   logic               rx_fifo_room;
   logic               rx_phy_done;
   logic               rx_phy_start;
   logic [PHY_NUM-1:0] rx_phy_sel;
   logic [PHY_NUM-1:0] rx_phy_ack;
   logic               rx_tout_err;

   modport master (
      input  rx_phy_req, rx_fifo_room, rx_phy_done,
      output rx_phy_start, rx_phy_sel, rx_phy_ack, rx_tout_err
   );

   modport slave (
      output rx_phy_req, rx_fifo_room, rx_phy_done,
      input  rx_phy_start, rx_phy_sel, rx_phy_ack, rx_tout_err
   );

endinterface

// File: rtl/rxc_rr_arb.sv
// Combinational round-robin grant: first eligible PHY above ptr, wrapping modulo PHY_NUM.
module rxc_rr_arb
   import rxc_pkg::*;
#(
   parameter int PHY_NUM = PHY_NUM_DEF,
   parameter int RR_W    = RR_W_DEF
) (
   input  logic [PHY_NUM-1:0] elig,
   input  logic [RR_W-1:0]    ptr,
   output logic               any,
   output logic [PHY_NUM-1:0] gnt,
   output logic [RR_W-1:0]    gnt_idx
);

   logic [RR_W-1:0] idx;

   always_comb begin
      any     = |elig;
      gnt_idx = '0;
      idx     = '0;
      // Scan farthest-first so the nearest eligible index is the last one written.
      for (int i = PHY_NUM; i >= 1; i--) begin
         idx = RR_W'((int'(ptr) + i) % PHY_NUM);
         if (elig[idx]) begin
            gnt_idx = idx;
         end
      end
      gnt = any ? (PHY_NUM'(1) << gnt_idx) : '0;
   end

endmodule

// File: rtl/rxc.sv
// Receive controller: round-robin PHY grant, FIFO-room gated start, ack on done, watchdog abort.
// Start one cycle after grant at the earliest; holds in REQ while the FIFO lacks room.
module rxc
   import rxc_pkg::*;
#(
   parameter int PHY_NUM = PHY_NUM_DEF,
   parameter int RR_W    = RR_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               reg_flush,
   input  logic [PHY_NUM-1:0] reg_mask,
   input  logic [31:0]        reg_tout,
   rxc_if.master              phy,
   output logic [1:0]         cur_state,
   output logic [31:0]        rx_frame_cnt
);

   rxc_state_e         state_q, state_d;
   logic [PHY_NUM-1:0] sel_q, sel_d;
   logic [31:0]        timer_q, timer_d;
   logic [31:0]        cnt_q, cnt_d;
   logic [RR_W-1:0]    ptr_q, ptr_d;

   logic [PHY_NUM-1:0] elig, gnt, ack;
   logic [RR_W-1:0]    gnt_idx;
   logic               any, start, err, tout_hit;

   assign elig     = phy.rx_phy_req & reg_mask;
   assign tout_hit = (reg_tout != 32'd0) && (timer_q == reg_tout - 32'd1);

   rxc_rr_arb #(.PHY_NUM(PHY_NUM), .RR_W(RR_W)) u_arb (
      .elig    (elig),
      .ptr     (ptr_q),
      .any     (any),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      timer_d = timer_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      start   = 1'b0;
      ack     = '0;
      err     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (any) begin
               sel_d   = gnt;
               ptr_d   = gnt_idx;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if ((sel_q & reg_mask) == '0) begin
               state_d = ST_IDLE;
               sel_d   = '0;
            end else if (phy.rx_fifo_room) begin
               state_d = ST_RECV;
               timer_d = '0;
               start   = 1'b1;
            end
         end
         ST_RECV: begin
            if (phy.rx_phy_done) begin
               state_d = ST_IDLE;
               sel_d   = '0;
               timer_d = '0;
               ack     = sel_q;
               cnt_d   = cnt_q + 32'd1;
            end else if (tout_hit) begin
               state_d = ST_IDLE;
               sel_d   = '0;
               timer_d = '0;
               err     = 1'b1;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            sel_d   = '0;
            timer_d = '0;
         end
      endcase
      // Flush abandons any transfer silently; the frame counter survives.
      if (reg_flush) begin
         state_d = ST_IDLE;
         sel_d   = '0;
         timer_d = '0;
         ptr_d   = RR_W'(PHY_NUM - 1);
         cnt_d   = cnt_q;
         start   = 1'b0;
         ack     = '0;
         err     = 1'b0;
      end
      if (!rst_n) begin
         start = 1'b0;
         ack   = '0;
         err   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         timer_q <= '0;
         cnt_q   <= '0;
         ptr_q   <= RR_W'(PHY_NUM - 1);
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         timer_q <= timer_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
      end
   end

   assign phy.rx_phy_start = start;
   assign phy.rx_phy_sel   = sel_q;
   assign phy.rx_phy_ack   = ack;
   assign phy.rx_tout_err  = err;
   assign cur_state        = state_q;
   assign rx_frame_cnt     = cnt_q;

endmodule
